// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial data stream, pattern
// configuration, counter clear and the match outputs.
// The master modport drives the stimulus side; the detector uses the slave modport.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               data;
    logic               valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               count_clr;
    logic               out;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output data, valid, cfg_load, pattern, pat_len, overlap, count_clr,
        input  out, match_count
    );

    modport slave (
        input  data, valid, cfg_load, pattern, pat_len, overlap, count_clr,
        output out, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. It shifts accepted bits into a history
// register and pulses out for one cycle when the last len_q bits equal the
// latched pattern. Overlapping or restart-after-match modes are selectable.
// The optional saturating match counter is built when SEQ_DET_MATCH_COUNT_EN
// is defined. Otherwise match_count reads 0 and count_clr is ignored.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_detector_param_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    // The legacy detector looked for 101. The reset length is limited by
    // MAX_LEN so that a 2-bit build still holds a legal length.
    localparam int                 DEF_LEN_I = (MAX_LEN < 3) ? MAX_LEN : 3;
    localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(DEF_LEN_I);
    localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(5);
    localparam logic [LEN_W-1:0]   FULL      = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               out_q, out_d;
    logic [MAX_LEN-1:0] len_mask;

    // A length of 0 means 1. A length above MAX_LEN is limited to MAX_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        if (int'(l) > MAX_LEN)
            return FULL;
        return l;
    endfunction

    // Mask that selects the low len_q bits of the history for comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (i < int'(len_q));
    end

    // Next-state logic. cfg_load has priority over valid. A match is judged on
    // the updated history and fill.
    always_comb begin
        // NOTE: every signal gets its hold or default value first, so no path
        // through the branches below leaves a signal unassigned. This avoids
        // inferring a latch.
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        out_d  = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.pattern;
            len_d  = clamp_len(bus.pat_len);
            ovl_d  = bus.overlap;
            fill_d = '0;
        end else if (bus.valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], bus.data};
            fill_d = (fill_q == FULL) ? fill_q : fill_q + LEN_W'(1);
            if ((fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0)) begin
                out_d = 1'b1;
                // In restart mode, the bits of this match cannot start the next one.
                if (!ovl_q)
                    fill_d = '0;
            end
        end
    end

    // Detector state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge inputs.
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= DEF_LEN;
            ovl_q  <= 1'b1;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            out_q  <= out_d;
        end
    end

    assign bus.out = out_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear first, then count. A clear and a match on the same edge leave 1.
    // The count saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.count_clr)
            cnt_d = '0;
        if (out_d && (cnt_d != '1))
            cnt_d = cnt_d + CNT_W'(1);
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.match_count = cnt_q;
`else
    // Counter not built. The clear input is deliberately left unconnected.
    logic unused_count_clr;
    assign unused_count_clr = bus.count_clr;
    assign bus.match_count  = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the generalised successor to the fixed 3-bit "101" detector FSM. It watches a qualified serial bit stream and pulses `out` when the last `pat_len` accepted bits equal a runtime-programmable pattern of up to `MAX_LEN` bits. Overlapping and non-overlapping match modes are supported, and an optional saturating match counter is available. It sits between a serial front-end and control logic that needs pattern/sync-word events.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits, must be ≥ 2.
- `CNT_W`, default 8: width of `match_count`.
- Derived `LEN_W` = $clog2(MAX_LEN+1).

Ports:
- `clk`  in  1  single clock; all state updates on posedge only.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  1  serial input bit.
- `valid`  in  1  `data` is accepted at a posedge only when `valid`=1.
- `cfg_load`  in  1  latch `pattern`, `pat_len` and `overlap` at this posedge.
- `pattern`  in  MAX_LEN  target bits; `pattern[pat_len-1]` is the first bit received and `pattern[0]` the last.
- `pat_len`  in  LEN_W  active pattern length.
- `overlap`  in  1  1 = overlapping matches allowed, 0 = restart after a match.
- `count_clr`  in  1  clear `match_count` (only with MATCH_COUNT_EN).
- `out`  out  1  registered one-cycle match pulse.
- `match_count`  out  CNT_W  saturating match total (only with MATCH_COUNT_EN).

## Operation
- State: history shift register `hist[MAX_LEN-1:0]`, fill counter `fill` (0..MAX_LEN, saturating), latched config `pat_q`/`len_q`/`ovl_q`.
- Accepted bit: `hist <= {hist[MAX_LEN-2:0], data}`; `fill <= min(fill+1, MAX_LEN)`.
- Match is evaluated on the updated values: `fill_next ≥ len_q` and `hist_next[len_q-1:0] == pat_q[len_q-1:0]`.
- On a match, `out` is 1 for the following cycle.
  - `ovl_q`=0: `fill <= 0`, so the bits of the match cannot start a new match.
  - `ovl_q`=1: `fill` is kept.
- No accepted bit: `hist` and `fill` hold, and `out` goes to 0.
- Config latch: `pat_len`=0 is treated as 1; `pat_len` > MAX_LEN is clamped to MAX_LEN.
- `cfg_load`:
  - Latches the config, clears `fill` and forces `out` to 0 next cycle.
  - Does not change `match_count`.
  - If `valid` is also 1 in that cycle, the data bit is dropped (config wins).
- Reset values:
  - `out`=0, `hist`=0, `fill`=0, `match_count`=0.
  - `pat_q`=…0101 (low 3 bits 101), `len_q`=3, `ovl_q`=1. Out of reset the block behaves as the legacy overlapping 101 detector.

## Timing
- Latency: the posedge that samples the final matching bit sets `out`; `out` is high for exactly that one following cycle.
- Back-to-back matches (overlap mode, e.g. `pat_len`=1): `out` stays high on consecutive cycles.
- `match_count` updates on the same edge that sets `out`.
- Reset mid-stream: the next cycle shows all reset values, and partial history is discarded.
- `reset` has priority over `cfg_load`, which has priority over `valid`.
- `count_clr` together with a match in the same cycle: `match_count` = 1.
- `match_count` saturates at 2^CNT_W−1 and never wraps.

## Configuration
- `SEQ_DET_MATCH_COUNT_EN` defined:
  - `match_count` register and `count_clr` port are implemented.
  - The count increments by one per `out` pulse, saturating.
- `SEQ_DET_MATCH_COUNT_EN` not defined:
  - The ports remain; `match_count` is tied to 0 and `count_clr` is ignored.
  - No counter flops are synthesised.
- Detection behaviour is identical in both builds.

## Test plan
- Reset default, no `cfg_load`: `valid`=1, bits 1,0,1,0,1 → `out` pulses after the 3rd and 5th bits; `match_count`=2 (with the macro).
- `cfg_load` with `pattern`=8'b0000_0101, `pat_len`=3, `overlap`=0; stream 1,0,1,0,1 → single `out` pulse after the 3rd bit; `match_count`=1.
- `pattern`=8'b1100_1011, `pat_len`=8, `overlap`=1; send 11001011, idle with `valid`=0 for 3 cycles, send 1 → `out` after the 8th bit only; `out` stays 0 during idle and after the 9th bit.
- `pat_len`=0 with `pattern[0]`=1; stream 1,1,0,1 → `out` high on 2 consecutive cycles, low, then high again (length clamped to 1).
- Mid-pattern events, pattern 101: `reset` after bits 1,0 then bit 1 → no pulse. `cfg_load` with `valid`=1 after bits 1,0, then bit 1 → no pulse and the bit is dropped.
- Counter, CNT_W=2, `pat_len`=1: 5 matches → `match_count`=3 (saturated). `count_clr` on the same edge as a match → 1.
